// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: FSM state encodings,
// FPU op-class opcodes, default latencies and the op-class decode helper.
package fpu_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_ADD,
        CLS_MUL,
        CLS_DIV,
        CLS_SQRT,
        CLS_MISC
    } op_class_t;

    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_SQRT = 4'b1011;

    localparam int DEF_LAT_ADD  = 3;
    localparam int DEF_LAT_MUL  = 4;
    localparam int DEF_LAT_DIV  = 16;
    localparam int DEF_LAT_SQRT = 16;
    localparam int DEF_LAT_MISC = 1;
    localparam int DEF_CNT_W    = 5;

    function automatic op_class_t op_class(input logic [3:0] op);
        case (op)
            OP_ADD:  return CLS_ADD;
            OP_MUL:  return CLS_MUL;
            OP_DIV:  return CLS_DIV;
            OP_SQRT: return CLS_SQRT;
            default: return CLS_MISC;
        endcase
    endfunction

endpackage

// File: rtl/fpu_lat_decode.sv
// Combinational map from the EX fpu_op field to the operation latency in cycles.
module fpu_lat_decode
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int LAT_ADD  = DEF_LAT_ADD,
    parameter int LAT_MUL  = DEF_LAT_MUL,
    parameter int LAT_DIV  = DEF_LAT_DIV,
    parameter int LAT_SQRT = DEF_LAT_SQRT,
    parameter int LAT_MISC = DEF_LAT_MISC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic [3:0]       i_fpu_op,
    output logic [CNT_W-1:0] o_lat
);

    always_comb begin
        o_lat = CNT_W'(LAT_MISC);
        case (op_class(i_fpu_op))
            CLS_ADD:  o_lat = CNT_W'(LAT_ADD);
            CLS_MUL:  o_lat = CNT_W'(LAT_MUL);
            CLS_DIV:  o_lat = CNT_W'(LAT_DIV);
            CLS_SQRT: o_lat = CNT_W'(LAT_SQRT);
            default:  o_lat = CNT_W'(LAT_MISC);
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Sequences one multi-cycle FPU operation from EX: latch operands, pulse start,
// count the op latency while stalling the front end, then strobe the result.
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int LAT_ADD  = DEF_LAT_ADD,
    parameter int LAT_MUL  = DEF_LAT_MUL,
    parameter int LAT_DIV  = DEF_LAT_DIV,
    parameter int LAT_SQRT = DEF_LAT_SQRT,
    parameter int LAT_MISC = DEF_LAT_MISC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        ex_valid,
    input  logic [3:0]  ex_fpu_op,
    input  logic [2:0]  ex_func3,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_dataA,
    input  logic [31:0] ex_dataB,
    input  logic        flush,
    input  logic        fpu_inprogress,
    input  logic [31:0] fpu_result,
    output logic        fpu_start,
    output logic [31:0] fpu_opA,
    output logic [31:0] fpu_opB,
    output logic [3:0]  fpu_op,
    output logic [2:0]  fpu_func3,
    output logic        stall,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        busy,
    output logic        err
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_lat;
    logic               w_accept;
    logic [31:0]        r_opA;
    logic [31:0]        r_opB;
    logic [3:0]         r_op;
    logic [2:0]         r_func3;
    logic [4:0]         r_rd;
    logic               r_err;

    fpu_lat_decode #(
        .LAT_ADD  (LAT_ADD),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .LAT_SQRT (LAT_SQRT),
        .LAT_MISC (LAT_MISC),
        .CNT_W    (CNT_W)
    ) u_lat_decode (
        .i_fpu_op (ex_fpu_op),
        .o_lat    (w_lat)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stall in IDLE is combinational so the accepting cycle already freezes the front end.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        stall        = 1'b0;
        fpu_start    = 1'b0;
        res_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ex_valid && !flush) begin
                    stall        = 1'b1;
                    w_accept     = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fpu_start = 1'b1;
                stall     = 1'b1;
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (flush) begin
                    w_state_next = ST_IDLE;
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // WAIT is entered with cnt = LAT-1 and leaves at cnt == 1, so it spans LAT-1 cycles.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_lat - CNT_W'(1);
        end else if (r_state == ST_WAIT && r_cnt > CNT_W'(1)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_opA   <= '0;
            r_opB   <= '0;
            r_op    <= '0;
            r_func3 <= '0;
            r_rd    <= '0;
        end else if (w_accept) begin
            r_opA   <= ex_dataA;
            r_opB   <= ex_dataB;
            r_op    <= ex_fpu_op;
            r_func3 <= ex_func3;
            r_rd    <= ex_rd;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_err <= 1'b0;
        end else if (r_state == ST_DONE && fpu_inprogress) begin
            r_err <= 1'b1;
        end
    end

    assign fpu_opA   = r_opA;
    assign fpu_opB   = r_opB;
    assign fpu_op    = r_op;
    assign fpu_func3 = r_func3;
    assign res_data  = fpu_result;
    assign res_rd    = r_rd;
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: table of FPU ops plus hand-built
// flush, back-to-back, stuck-FPU and mid-op reset sequences, with a result scoreboard.
module tb_fpu_issue_ctrl;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        ex_valid = 1'b0;
    logic [3:0]  ex_fpu_op = '0;
    logic [2:0]  ex_func3 = '0;
    logic [4:0]  ex_rd = '0;
    logic [31:0] ex_dataA = '0;
    logic [31:0] ex_dataB = '0;
    logic        flush = 1'b0;
    logic        fpu_inprogress = 1'b0;
    logic [31:0] fpu_result = '0;
    logic        fpu_start;
    logic [31:0] fpu_opA;
    logic [31:0] fpu_opB;
    logic [3:0]  fpu_op;
    logic [2:0]  fpu_func3;
    logic        stall;
    logic        res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        busy;
    logic        err;

    fpu_issue_ctrl dut (
        .clock          (clock),
        .clear          (clear),
        .ex_valid       (ex_valid),
        .ex_fpu_op      (ex_fpu_op),
        .ex_func3       (ex_func3),
        .ex_rd          (ex_rd),
        .ex_dataA       (ex_dataA),
        .ex_dataB       (ex_dataB),
        .flush          (flush),
        .fpu_inprogress (fpu_inprogress),
        .fpu_result     (fpu_result),
        .fpu_start      (fpu_start),
        .fpu_opA        (fpu_opA),
        .fpu_opB        (fpu_opB),
        .fpu_op         (fpu_op),
        .fpu_func3      (fpu_func3),
        .stall          (stall),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_rd         (res_rd),
        .busy           (busy),
        .err            (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic exp_err = 1'b0;

    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'b1000: return 3;
            4'b1001: return 4;
            4'b1010: return 16;
            4'b1011: return 16;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Scoreboard: every result strobe must match the oldest outstanding op.
    always @(negedge clock) begin
        if (res_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_res_valid: got=1 want=0 rd=%0d", res_rd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_rd", 32'(res_rd), 32'(e.rd));
                check("res_data", res_data, e.data);
                $display("result rd=%0d data=%h", res_rd, res_data);
            end
        end
    end

    task automatic drive_idle();
        ex_valid       = 1'b0;
        flush          = 1'b0;
        clear          = 1'b0;
        fpu_inprogress = 1'b0;
        fpu_result     = 32'h0BAD_0000;
    endtask

    task automatic idle_cycle();
        @(posedge clock); #1;
        drive_idle();
        @(negedge clock);
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_start", 32'(fpu_start), 32'd0);
        check("idle_err", 32'(err), 32'(exp_err));
    endtask

    task automatic check_reset_state();
        @(posedge clock); #1;
        drive_idle();
        @(negedge clock);
        check("rst_start", 32'(fpu_start), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_opA", fpu_opA, 32'd0);
        check("rst_opB", fpu_opB, 32'd0);
        check("rst_rd", 32'(res_rd), 32'd0);
        check("rst_op", 32'(fpu_op), 32'd0);
        check("rst_func3", 32'(fpu_func3), 32'd0);
        $display("reset state checked");
    endtask

    // Presents one op in EX from acceptance (k=0) through DONE (k=LAT+1), or
    // stops after cycle stop_k where flush (or clear, if use_clear) is raised.
    task automatic run_op(input logic [3:0] op, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                          input bit stuck, input int stop_k, input bit use_clear);
        int lat;
        int last;
        lat  = lat_of(op);
        last = (stop_k >= 0) ? stop_k : lat + 1;
        for (int k = 0; k <= last; k++) begin
            @(posedge clock); #1;
            ex_valid       = 1'b1;
            ex_fpu_op      = op;
            ex_func3       = (k == 0) ? f3 : ~f3;
            ex_rd          = (k == 0) ? rd : ~rd;
            ex_dataA       = (k == 0) ? a : ~a;
            ex_dataB       = (k == 0) ? b : ~b;
            fpu_inprogress = (k >= 1 && k <= lat) || (stuck && k == lat + 1);
            fpu_result     = (k == lat + 1) ? res : (32'hDEAD_BEEF ^ 32'(k));
            flush          = !use_clear && (k == stop_k);
            clear          = use_clear && (k == stop_k);
            if (k == 0 && !use_clear && (stop_k < 0 || stop_k == lat + 1)) begin
                exp_t e;
                e.rd   = rd;
                e.data = res;
                sb.push_back(e);
            end
            @(negedge clock);
            check($sformatf("start_k%0d", k), 32'(fpu_start), 32'(k == 1));
            check($sformatf("stall_k%0d", k), 32'(stall), 32'(k <= lat));
            check($sformatf("busy_k%0d", k), 32'(busy), 32'(k >= 1));
            check($sformatf("res_valid_k%0d", k), 32'(res_valid), 32'(k == lat + 1));
            check($sformatf("err_k%0d", k), 32'(err), 32'(exp_err));
            if (k >= 1) begin
                check("opA_hold", fpu_opA, a);
                check("opB_hold", fpu_opB, b);
                check("op_hold", 32'(fpu_op), 32'(op));
                check("func3_hold", 32'(fpu_func3), 32'(f3));
            end
            if (stuck && k == lat + 1) exp_err = 1'b1;
        end
        $display("op=%b rd=%0d lat=%0d stop_k=%0d clear=%0d stuck=%0d", op, rd, lat, stop_k,
                 use_clear, stuck);
    endtask

    initial begin
        vecs[0] = '{4'b1000, 3'd0, 5'd3,  32'h3F800000, 32'h40000000, 32'h40400000};
        vecs[1] = '{4'b1001, 3'd1, 5'd7,  32'h40000000, 32'h40400000, 32'h40C00000};
        vecs[2] = '{4'b1010, 3'd2, 5'd12, 32'h40C00000, 32'h40000000, 32'h40400000};
        vecs[3] = '{4'b1011, 3'd3, 5'd31, 32'h41100000, 32'h00000000, 32'h40400000};
        vecs[4] = '{4'b1100, 3'd4, 5'd1,  32'h12345678, 32'h9ABCDEF0, 32'h00000001};
        vecs[5] = '{4'b0000, 3'd5, 5'd17, 32'hC0000000, 32'h40000000, 32'h00000000};
        vecs[6] = '{4'b1111, 3'd7, 5'd22, 32'hFFFFFFFF, 32'h00000001, 32'hA5A5A5A5};
        vecs[7] = '{4'b1000, 3'd6, 5'd9,  32'hBF800000, 32'h3F800000, 32'h00000000};

        @(posedge clock); #1;
        drive_idle();
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b1;
        check_reset_state();

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].f3, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].res,
                   1'b0, -1, 1'b0);
            idle_cycle();
        end

        // Back-to-back MUL then ADD: second accepted the cycle after DONE.
        run_op(4'b1001, 3'd0, 5'd4, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, -1, 1'b0);
        run_op(4'b1000, 3'd0, 5'd5, 32'h40400000, 32'h3F800000, 32'h40800000, 1'b0, -1, 1'b0);
        idle_cycle();

        // Flush mid-WAIT: no result, front end released next cycle.
        run_op(4'b1010, 3'd0, 5'd6, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 6, 1'b0);
        idle_cycle();
        idle_cycle();

        // Flush mid-WAIT followed by a new ADD accepted immediately.
        run_op(4'b1010, 3'd0, 5'd8, 32'h44444444, 32'h55555555, 32'h66666666, 1'b0, 6, 1'b0);
        run_op(4'b1000, 3'd1, 5'd10, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, -1, 1'b0);
        idle_cycle();

        // Flush in IDLE blocks acceptance.
        @(posedge clock); #1;
        drive_idle();
        ex_valid  = 1'b1;
        ex_fpu_op = 4'b1001;
        flush     = 1'b1;
        @(negedge clock);
        check("flush_idle_stall", 32'(stall), 32'd0);
        idle_cycle();

        // Flush in DONE leaves the result strobe intact.
        run_op(4'b1000, 3'd2, 5'd11, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 4, 1'b0);
        idle_cycle();

        // Stuck FPU: err sets after DONE and persists over later ops.
        run_op(4'b1000, 3'd0, 5'd13, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1, -1, 1'b0);
        idle_cycle();
        run_op(4'b1001, 3'd0, 5'd14, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, -1, 1'b0);
        idle_cycle();

        // Clear asserted mid-WAIT of a DIV overrides everything.
        run_op(4'b1010, 3'd0, 5'd15, 32'h77777777, 32'h88888888, 32'h99999999, 1'b0, 5, 1'b1);
        exp_err = 1'b0;
        check_reset_state();
        idle_cycle();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
